smul_acc: RTL and testbench

- Parametrised successor to the fixed-width pipelined signed multiplier.
- Adds independent operand widths, configurable input pipeline depth, and valid/first/last framing.
- Accumulates signed products with guard bits, then rounds, shifts and saturates the sum to a fixed-point output.
- Sits in filter/dot-product datapaths and feeds fixed-point consumers that need one sum per framed group of terms.

---
 rtl/smul_acc.sv | 167 ++++++++++++++++
 tb/tb_smul_acc.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smul_acc.sv
// Pipelined signed multiply-accumulate with first/last framing.
// One rounded, shifted and saturated sum is strobed out per framed group of terms.
module smul_acc #(
  parameter int A_WIDTH   = 18,
  parameter int B_WIDTH   = 18,
  parameter int IN_STAGES = 2,
  parameter int GUARD     = 8,
  parameter int SHIFT     = 0,
  parameter int OUT_WIDTH = 44
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic signed [A_WIDTH-1:0]   a,
  input  logic signed [B_WIDTH-1:0]   b,
  output logic                        out_valid,
  output logic signed [OUT_WIDTH-1:0] out,
  output logic                        out_sat
);
  // Handshake: no backpressure. A term is taken on every rising edge with
  // in_valid=1; in_first/in_last only mean something while in_valid=1.
  // out_valid is a single-cycle strobe, and out/out_sat hold between strobes.

  localparam int PW    = A_WIDTH + B_WIDTH;
  localparam int ACC_W = PW + GUARD;
  localparam int QW    = ACC_W + 1;
  localparam int CW    = ((QW > OUT_WIDTH) ? QW : OUT_WIDTH) + 1;

  localparam logic [QW-1:0]        RND_ONE = {{(QW-1){1'b0}}, 1'b1};
  localparam logic signed [QW-1:0] RND     = (RND_ONE << SHIFT) >> 1;
  localparam logic [CW-1:0]        CW_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] SAT_MAX = (CW_ONE << (OUT_WIDTH - 1)) - CW_ONE;
  localparam logic signed [CW-1:0] SAT_MIN = ~SAT_MAX;

  // Input register chain (operands unreset, control bits reset)
  logic signed [A_WIDTH-1:0] a_sr [IN_STAGES];
  logic signed [B_WIDTH-1:0] b_sr [IN_STAGES];
  logic [IN_STAGES-1:0]      v_sr, f_sr, l_sr;

  always_ff @(posedge clk) begin
    a_sr[0] <= a;
    b_sr[0] <= b;
    for (int i = 1; i < IN_STAGES; i++) begin
      a_sr[i] <= a_sr[i-1];
      b_sr[i] <= b_sr[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_sr <= '0;
      f_sr <= '0;
      l_sr <= '0;
    end else begin
      v_sr[0] <= in_valid;
      f_sr[0] <= in_valid & in_first;
      l_sr[0] <= in_valid & in_last;
      for (int i = 1; i < IN_STAGES; i++) begin
        v_sr[i] <= v_sr[i-1];
        f_sr[i] <= f_sr[i-1];
        l_sr[i] <= l_sr[i-1];
      end
    end
  end

  // Product stage
  logic signed [PW-1:0] a_ext, b_ext, p_q;
  logic                 p_v, p_f, p_l;

  always_comb begin
    a_ext = PW'(a_sr[IN_STAGES-1]);
    b_ext = PW'(b_sr[IN_STAGES-1]);
  end

  always_ff @(posedge clk) p_q <= a_ext * b_ext;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_v <= 1'b0;
      p_f <= 1'b0;
      p_l <= 1'b0;
    end else begin
      p_v <= v_sr[IN_STAGES-1];
      p_f <= f_sr[IN_STAGES-1];
      p_l <= l_sr[IN_STAGES-1];
    end
  end

  // Accumulate stage; ovf is sticky within a sum and cleared by a first term
  logic signed [ACC_W-1:0] acc, acc_base, p_ext, acc_sum;
  logic                    acc_ovf, ovf_base, add_ovf, acc_l;

  always_comb begin
    p_ext    = ACC_W'(p_q);
    acc_base = p_f ? '0 : acc;
    ovf_base = p_f ? 1'b0 : acc_ovf;
    acc_sum  = acc_base + p_ext;
    add_ovf  = (acc_base[ACC_W-1] == p_ext[ACC_W-1]) &&
               (acc_sum[ACC_W-1] != p_ext[ACC_W-1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      acc_l   <= 1'b0;
    end else begin
      acc_l <= p_v & p_l;
      if (p_v) begin
        acc     <= acc_sum;
        acc_ovf <= ovf_base | add_ovf;
      end
    end
  end

  // Rounding stage: one extra bit so the half-LSB add never wraps
  logic signed [QW-1:0] r_q;
  logic                 r_v, r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= '0;
      r_v   <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      r_v <= acc_l;
      if (acc_l) begin
        r_q   <= QW'(acc) + RND;
        r_ovf <= acc_ovf;
      end
    end
  end

  // Shift and saturate
  logic signed [CW-1:0] q_ext, sat_q;
  logic                 sat_hit;

  always_comb begin
    q_ext   = CW'(r_q >>> SHIFT);
    sat_q   = q_ext;
    sat_hit = 1'b0;
    if (q_ext > SAT_MAX) begin
      sat_q   = SAT_MAX;
      sat_hit = 1'b1;
    end else if (q_ext < SAT_MIN) begin
      sat_q   = SAT_MIN;
      sat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= r_v;
      if (r_v) begin
        out     <= OUT_WIDTH'(sat_q);
        out_sat <= sat_hit | r_ovf;
      end
    end
  end

endmodule

// File: tb/tb_smul_acc.sv
// Bench for smul_acc: a default instance and a narrow 8x8/SHIFT=4/OUT=8 instance,
// each checked every cycle against a plain-arithmetic model of framed sums.
module tb_smul_acc;
  localparam int LAT = 2 + 4;  // drive cycle -> strobe cycle (IN_STAGES=2)

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic               v_d, f_d, l_d, ov_d, sat_d;
  logic signed [17:0] a_d, b_d;
  logic signed [43:0] out_d;
  logic               v_s, f_s, l_s, ov_s, sat_s;
  logic signed [7:0]  a_s, b_s;
  logic signed [7:0]  out_s;

  smul_acc dut_d (
    .clk(clk), .reset(reset), .in_valid(v_d), .in_first(f_d), .in_last(l_d),
    .a(a_d), .b(b_d), .out_valid(ov_d), .out(out_d), .out_sat(sat_d)
  );

  smul_acc #(.A_WIDTH(8), .B_WIDTH(8), .IN_STAGES(2), .GUARD(4), .SHIFT(4), .OUT_WIDTH(8)) dut_s (
    .clk(clk), .reset(reset), .in_valid(v_s), .in_first(f_s), .in_last(l_s),
    .a(a_s), .b(b_s), .out_valid(ov_s), .out(out_s), .out_sat(sat_s)
  );

  typedef struct {
    int     id;
    int     cyc;
    longint val;
    bit     sat;
  } exp_t;
  exp_t exp_q[$];

  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  longint m_acc [2];
  bit     m_ovf [2];
  longint hold_val [2];
  bit     hold_sat [2];
  int     strobes [2];
  int     acc_w [2] = '{44, 20};
  int     shf   [2] = '{0, 4};
  int     ow    [2] = '{44, 8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: modular accumulation with sticky wrap flag, then round/shift/saturate
  function automatic void model_term(input int id, input longint a, input longint b,
                                     input bit f, input bit l);
    longint lim, s, r, q, omax;
    bit     ov, sat;
    exp_t   e;
    lim = longint'(1) << (acc_w[id] - 1);
    s   = (f ? 0 : m_acc[id]) + a * b;
    ov  = f ? 1'b0 : m_ovf[id];
    if (s >= lim) begin
      s  = s - 2 * lim;
      ov = 1'b1;
    end else if (s < -lim) begin
      s  = s + 2 * lim;
      ov = 1'b1;
    end
    m_acc[id] = s;
    m_ovf[id] = ov;
    if (l) begin
      r    = s + ((shf[id] > 0) ? (longint'(1) << (shf[id] - 1)) : 0);
      q    = r >>> shf[id];
      omax = (longint'(1) << (ow[id] - 1)) - 1;
      sat  = 1'b0;
      if (q > omax) begin
        q = omax; sat = 1'b1;
      end else if (q < -omax - 1) begin
        q = -omax - 1; sat = 1'b1;
      end
      e.id = id; e.cyc = cyc + LAT; e.val = q; e.sat = sat | ov;
      exp_q.push_back(e);
    end
  endfunction

  // Compare process: every cycle, both instances
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      logic               v, s;
      logic signed [63:0] o;
      int                 idx;
      v = (id == 1) ? ov_s : ov_d;
      s = (id == 1) ? sat_s : sat_d;
      o = (id == 1) ? 64'(out_s) : 64'(out_d);
      if (!reset) begin
        check($sformatf("d%0d_rst_valid", id), 64'(v), 0);
        check($sformatf("d%0d_rst_out", id), o, 0);
        check($sformatf("d%0d_rst_sat", id), 64'(s), 0);
      end else begin
        if (v === 1'b1) strobes[id]++;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++)
          if (exp_q[i].id == id) begin
            idx = i;
            break;
          end
        if (idx >= 0 && exp_q[idx].cyc == cyc) begin
          check($sformatf("d%0d_strobe", id), 64'(v), 1);
          check($sformatf("d%0d_out", id), o, exp_q[idx].val);
          check($sformatf("d%0d_sat", id), 64'(s), 64'(exp_q[idx].sat));
          hold_val[id] = exp_q[idx].val;
          hold_sat[id] = exp_q[idx].sat;
          exp_q.delete(idx);
        end else begin
          check($sformatf("d%0d_idle_valid", id), 64'(v), 0);
          check($sformatf("d%0d_hold_out", id), o, hold_val[id]);
          check($sformatf("d%0d_hold_sat", id), 64'(s), 64'(hold_sat[id]));
        end
      end
    end
  end

  task automatic clear_model();
    exp_q.delete();
    for (int id = 0; id < 2; id++) begin
      m_acc[id] = 0; m_ovf[id] = 1'b0; hold_val[id] = 0; hold_sat[id] = 1'b0;
    end
  endtask

  task automatic term(input int id, input longint a, input longint b,
                      input bit f, input bit l);
    if (id == 0) begin
      v_d = 1'b1; a_d = 18'(a); b_d = 18'(b); f_d = f; l_d = l;
    end else begin
      v_s = 1'b1; a_s = 8'(a); b_s = 8'(b); f_s = f; l_s = l;
    end
    model_term(id, a, b, f, l);
    @(posedge clk);
    #1;
    v_d = 1'b0; f_d = 1'b0; l_d = 1'b0;
    v_s = 1'b0; f_s = 1'b0; l_s = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", 64'(exp_q.size()), 0);
    idle(2);
  endtask

  task automatic sum1(input int id, input longint a, input longint b,
                      input longint exp_out, input bit exp_sat, input string name);
    strobes[id] = 0;
    term(id, a, b, 1'b1, 1'b1);
    wait_drain();
    check({name, "_model_out"}, hold_val[id], exp_out);
    check({name, "_model_sat"}, 64'(hold_sat[id]), 64'(exp_sat));
    check({name, "_strobes"}, 64'(strobes[id]), 1);
  endtask

  initial begin
    reset = 1'b0;
    v_d = 0; f_d = 0; l_d = 0; a_d = 0; b_d = 0;
    v_s = 0; f_s = 0; l_s = 0; a_s = 0; b_s = 0;
    clear_model();
    strobes[0] = 0; strobes[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    // single-product sum on defaults
    sum1(0, 3, -5, -15, 1'b0, "t1");

    // framed sum with bubbles
    strobes[0] = 0;
    term(0, 1, 2, 1'b1, 1'b0);
    term(0, 3, 4, 1'b0, 1'b0);
    idle(2);
    term(0, -5, 6, 1'b0, 1'b0);
    term(0, 7, -8, 1'b0, 1'b1);
    wait_drain();
    check("t2_model_out", hold_val[0], -72);
    check("t2_strobes", 64'(strobes[0]), 1);

    // rounding on the narrow instance
    sum1(1, 16, 8, 8, 1'b0, "t3a");
    sum1(1, 17, 1, 1, 1'b0, "t3b");
    sum1(1, 24, 1, 2, 1'b0, "t3c");
    sum1(1, -24, 1, -1, 1'b0, "t3d");

    // saturation both ways
    sum1(1, 127, 127, 127, 1'b1, "t4a");
    sum1(1, -128, 127, -128, 1'b1, "t4b");

    // accumulator wrap on the 33rd term
    strobes[1] = 0;
    for (int i = 0; i < 33; i++) term(1, 127, 127, i == 0, i == 32);
    wait_drain();
    check("t4c_model_out", hold_val[1], -128);
    check("t4c_model_sat", 64'(hold_sat[1]), 1);
    check("t4c_strobes", 64'(strobes[1]), 1);
    sum1(1, 1, 16, 1, 1'b0, "t4d");

    // back-to-back sums
    strobes[0] = 0;
    term(0, 2, 3, 1'b1, 1'b1);
    term(0, 4, 5, 1'b1, 1'b1);
    wait_drain();
    check("t5_model_out", hold_val[0], 20);
    check("t5_strobes", 64'(strobes[0]), 2);

    // reset mid-sum; terms offered during reset must vanish
    strobes[0] = 0;
    term(0, 1, 1, 1'b1, 1'b0);
    term(0, 1, 1, 1'b0, 1'b0);
    reset = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    v_d = 1'b1; a_d = 3; b_d = 3;
    @(posedge clk);
    #1;
    a_d = 4; l_d = 1'b1;
    @(posedge clk);
    #1;
    v_d = 1'b0; l_d = 1'b0;
    reset = 1'b1;
    idle(10);
    check("t6_no_strobe", 64'(strobes[0]), 0);
    sum1(0, 2, 2, 4, 1'b0, "t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
